// File: rtl/bht_update_sched_pkg.sv
// rtl/bht_update_sched_pkg.sv - shared types, constants and helpers for the BHT update scheduler
// Contents: bht_entry_t table word, flush counter value, FSM state codes,
//           saturating 2-bit counter helpers, virtual address width.
package bht_update_sched_pkg;

    localparam int VLEN = 64;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    localparam logic [1:0] BHT_CTR_FLUSH = 2'b10;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bht_update_sched_rr_arbiter.sv
// rtl/bht_update_sched_rr_arbiter.sv - round-robin arbiter with onehot grant and pointer update
// Ports: clk_i/rst_ni clock and async active-low reset; req_i request vector;
//        adv_i moves the pointer past the current winner; gnt_o onehot winner;
//        idx_o binary winner index (valid when gnt_o is non-zero).
module bht_rr_arbiter #(
    parameter int NR_REQ = 2,
    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_REQ-1:0] req_i,
    input  logic              adv_i,
    output logic [NR_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int c;
        w_found = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            c = int'(r_ptr) + i;
            if (c >= NR_REQ) c = c - NR_REQ;
            if (!w_found && req_i[c[IDX_W-1:0]]) begin
                w_found = 1'b1;
                idx_o   = IDX_W'(c);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (w_found) gnt_o[idx_o] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (adv_i) begin
            r_ptr <= (idx_o == IDX_W'(NR_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/bht_update_sched.sv
// rtl/bht_update_sched.sv - write-side scheduler for a 1R1W gshare branch history table
// Arbitrates update sources, runs a 2-stage read-modify-write of 2-bit counters,
// owns the global history register and sweeps the table on reset/flush.
// Ports: clk_i, rst_ni (async, active-low); flush_i starts a sweep; debug_mode_i discards updates;
//        upd_valid_i/upd_ready_o/upd_pc_i/upd_taken_i update handshake per source;
//        tbl_raddr_o/tbl_rdata_i table read (data next cycle); tbl_we_o/tbl_waddr_o/tbl_wdata_o write;
//        ghr_o current history; busy_o sweep in progress.
// Option: BHT_SCHED_BYPASS_EN forwards the S1 result to a same-index follower instead of stalling.
module bht_update_sched
    import bht_update_sched_pkg::*;
#(
    parameter int NR_ENTRIES = 1024,
    parameter int NR_REQ     = 2,
    localparam int INDEX_BITS = $clog2(NR_ENTRIES),
    localparam int IDX_W      = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic [NR_REQ-1:0]      upd_valid_i,
    output logic [NR_REQ-1:0]      upd_ready_o,
    input  logic [NR_REQ*VLEN-1:0] upd_pc_i,
    input  logic [NR_REQ-1:0]      upd_taken_i,
    output logic [INDEX_BITS-1:0]  tbl_raddr_o,
    input  logic [2:0]             tbl_rdata_i,
    output logic                   tbl_we_o,
    output logic [INDEX_BITS-1:0]  tbl_waddr_o,
    output logic [2:0]             tbl_wdata_o,
    output logic [INDEX_BITS-1:0]  ghr_o,
    output logic                   busy_o
);

    logic [1:0]            r_state;
    logic [INDEX_BITS-1:0] r_cnt;
    logic [INDEX_BITS-1:0] r_ghr;
    logic                  r_s1_valid;
    logic [INDEX_BITS-1:0] r_s1_idx;
    logic                  r_s1_taken;
    // Sweep writes are registered so every output is quiet while reset is held.
    logic                  r_sw_we;
    logic [INDEX_BITS-1:0] r_sw_addr;

    logic                  w_idle;
    logic [NR_REQ-1:0]     w_gnt_oh;
    logic [IDX_W-1:0]      w_win;
    logic [VLEN-1:0]       w_win_pc;
    logic                  w_win_taken;
    logic [INDEX_BITS-1:0] w_s0_idx;
    logic                  w_hazard;
    logic                  w_grant;
    logic                  w_load;
    logic                  w_s1_wr;
    logic [1:0]            w_ctr_src;
    logic [1:0]            w_ctr_new;
    bht_entry_t            w_wentry;
    logic                  w_unused;

    bht_rr_arbiter #(.NR_REQ(NR_REQ)) i_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (upd_valid_i),
        .adv_i  (w_grant),
        .gnt_o  (w_gnt_oh),
        .idx_o  (w_win)
    );

    always_comb begin
        w_win_pc    = '0;
        w_win_taken = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_win_pc    = upd_pc_i[i*VLEN +: VLEN];
                w_win_taken = upd_taken_i[i];
            end
        end
    end

    assign w_idle   = (r_state == ST_IDLE);
    assign w_s0_idx = r_ghr ^ w_win_pc[INDEX_BITS-1:0];

`ifdef BHT_SCHED_BYPASS_EN
    logic       r_fwd_hit;
    logic [1:0] r_fwd_ctr;

    assign w_hazard  = 1'b0;
    // The SRAM read raced the previous same-index write; use the value just written.
    assign w_ctr_src = r_fwd_hit ? r_fwd_ctr : tbl_rdata_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fwd_hit <= 1'b0;
            r_fwd_ctr <= 2'b00;
        end else begin
            r_fwd_hit <= w_load && w_s1_wr && (w_s0_idx == r_s1_idx);
            r_fwd_ctr <= w_ctr_new;
        end
    end
`else
    // Without forwarding a same-index follower waits one cycle so its read sees the write.
    assign w_hazard  = r_s1_valid && (w_s0_idx == r_s1_idx);
    assign w_ctr_src = tbl_rdata_i[1:0];
`endif

    // Flush has priority over any grant.
    assign w_grant   = w_idle && !flush_i && (|w_gnt_oh) && !w_hazard;
    assign w_load    = w_grant && !debug_mode_i;
    assign w_s1_wr   = r_s1_valid && !flush_i;
    assign w_ctr_new = r_s1_taken ? sat_inc(w_ctr_src) : sat_dec(w_ctr_src);

    always_comb begin
        w_wentry = '0;
        if (w_s1_wr) begin
            w_wentry.valid = 1'b1;
            w_wentry.ctr   = w_ctr_new;
        end else if (r_sw_we) begin
            w_wentry.valid = 1'b0;
            w_wentry.ctr   = BHT_CTR_FLUSH;
        end
    end

    assign upd_ready_o = w_grant ? w_gnt_oh : '0;
    assign tbl_raddr_o = w_grant ? w_s0_idx : '0;
    // S1 and sweep writes never coincide: S1 needs a grant in IDLE the cycle before.
    assign tbl_we_o    = w_s1_wr || r_sw_we;
    assign tbl_waddr_o = w_s1_wr ? r_s1_idx : (r_sw_we ? r_sw_addr : '0);
    assign tbl_wdata_o = w_wentry;
    assign ghr_o       = r_ghr;
    assign busy_o      = !w_idle;

    assign w_unused = tbl_rdata_i[2] ^ (^w_win_pc[VLEN-1:INDEX_BITS]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_sw_we   <= 1'b0;
            r_sw_addr <= '0;
        end else begin
            r_sw_we <= 1'b0;
            case (r_state)
                ST_INIT, ST_SWEEP: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_sw_we   <= 1'b1;
                        r_sw_addr <= r_cnt;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == '1) r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_taken <= 1'b0;
        end else begin
            r_s1_valid <= w_load;
            if (flush_i) begin
                r_ghr <= '0;
            end else if (w_load) begin
                r_ghr <= {r_ghr[INDEX_BITS-2:0], w_win_taken};
            end
            if (w_load) begin
                r_s1_idx   <= w_s0_idx;
                r_s1_taken <= w_win_taken;
            end
        end
    end

endmodule
